// File: rtl/regfile_2r1w_pkg.sv
// Shared pipeline constants and types for the integer register file.
// Index helpers keep the x0 / out-of-range rules in one place.
package regfile_2r1w_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [AW-1:0]   regIdx_t;
    typedef xlen_t [NREG-1:1] regArray_t;

    localparam regIdx_t REG_ZERO = '0;
    localparam regIdx_t REG_RA   = regIdx_t'(1);
    localparam regIdx_t REG_SP   = regIdx_t'(2);

    function automatic logic inRange(regIdx_t idx);
        return 32'(idx) < NREG;
    endfunction

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One combinational read port: x0, range, reset-zero and
// write-through bypass selection in front of the storage view.
module rf_read_port
    import regfile_2r1w_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic      rst,
    input  regIdx_t   idx,
    input  regArray_t regs,
    input  logic      wrEn,
    input  regIdx_t   wrIdx,
    input  xlen_t     wrData,
    output xlen_t     data
);

    always_comb begin
        data = '0;
        if (rst || idx == REG_ZERO || !inRange(idx)) begin
            data = '0;
        end else if (BYPASS && wrEn && wrIdx == idx) begin
            data = wrData;
        end else begin
            data = regs[idx];
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Integer register file, two combinational reads and one writeback
// write; x0 is not stored and reads as zero.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwriteW,
    input  logic [AW-1:0]   rdW,
    input  logic [XLEN-1:0] resultW,
    input  logic [AW-1:0]   rs1D,
    input  logic [AW-1:0]   rs2D,
    output logic [XLEN-1:0] rd1D,
    output logic [XLEN-1:0] rd2D
);

    regArray_t regs;
    logic      wrValid;

    // wrValid already excludes x0 and unimplemented indices
    assign wrValid = regwriteW && rdW != REG_ZERO && inRange(rdW);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wrValid) begin
            regs[rdW] <= resultW;
        end
    end

    rf_read_port #(
        .BYPASS(BYPASS)
    ) port1 (
        .rst   (rst),
        .idx   (rs1D),
        .regs  (regs),
        .wrEn  (wrValid),
        .wrIdx (rdW),
        .wrData(resultW),
        .data  (rd1D)
    );

    rf_read_port #(
        .BYPASS(BYPASS)
    ) port2 (
        .rst   (rst),
        .idx   (rs2D),
        .regs  (regs),
        .wrEn  (wrValid),
        .wrIdx (rdW),
        .wrData(resultW),
        .data  (rd2D)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: bypass and non-bypass builds side by side,
// directed vectors plus random traffic against an array model.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [31:0] rd1B, rd2B, rd1N, rd2N;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] model [32];

    regfile_2r1w #(.BYPASS(1'b1)) dutB (
        .clk(clk), .rst(rst), .regwriteW(regwriteW), .rdW(rdW),
        .resultW(resultW), .rs1D(rs1D), .rs2D(rs2D),
        .rd1D(rd1B), .rd2D(rd2B)
    );

    regfile_2r1w #(.BYPASS(1'b0)) dutN (
        .clk(clk), .rst(rst), .regwriteW(regwriteW), .rdW(rdW),
        .resultW(resultW), .rs1D(rs1D), .rs2D(rs2D),
        .rd1D(rd1N), .rd2D(rd2N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1B;
        logic [31:0] e2B;
        logic [31:0] e1N;
        logic [31:0] e2N;
    } vec_t;

    vec_t vecs [9];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic we, logic [4:0] rd, logic [31:0] res,
                         logic [4:0] a, logic [4:0] b);
        regwriteW = we;
        rdW       = rd;
        resultW   = res;
        rs1D      = a;
        rs2D      = b;
    endtask

    // Clock edge: model commits what the DUT samples on that edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (regwriteW && rdW != 5'd0) begin
            model[rdW] = resultW;
        end
        #1;
    endtask

    function automatic logic [31:0] expRead(logic [4:0] idx, bit byp);
        if (rst || idx == 5'd0) return '0;
        if (byp && regwriteW && rdW == idx) return resultW;
        return model[idx];
    endfunction

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,
                    32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5,
                    32'hDEADBEEF, 32'hDEADBEEF,
                    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd7, 32'h1, 5'd7, 5'd7,
                    32'h1, 32'h1, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 5'd7, 32'h2, 5'd7, 5'd7,
                    32'h2, 32'h2, 32'h1, 32'h1};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7,
                    32'h2, 32'h2, 32'h2, 32'h2};
        vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,
                    32'hCAFEF00D, 32'hDEADBEEF,
                    32'h0, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd30,
                    32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};

        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset, with a write pending that must not land
        rst = 1'b1;
        drive(1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd9);
        #1;
        check("rst_rd1B", rd1B, 32'h0);
        check("rst_rd2N", rd2N, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 32; i++) begin
            rs1D = 5'(i);
            rs2D = 5'(31 - i);
            #1;
            check($sformatf("init_rd1B[%0d]", i), rd1B, 32'h0);
            check($sformatf("init_rd2B[%0d]", i), rd2B, 32'h0);
            check($sformatf("init_rd1N[%0d]", i), rd1N, 32'h0);
            check($sformatf("init_rd2N[%0d]", i), rd2N, 32'h0);
        end

        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].we, vecs[v].rd, vecs[v].res,
                  vecs[v].r1, vecs[v].r2);
            #1;
            check($sformatf("vec%0d_rd1B", v), rd1B, vecs[v].e1B);
            check($sformatf("vec%0d_rd2B", v), rd2B, vecs[v].e2B);
            check($sformatf("vec%0d_rd1N", v), rd1N, vecs[v].e1N);
            check($sformatf("vec%0d_rd2N", v), rd2N, vecs[v].e2N);
            tick();
        end

        // Reset beats a simultaneous write
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        check("x3_before_rst", rd1N, 32'hA5A5A5A5);
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
        #1;
        check("rst_byp_rd1B", rd1B, 32'h0);
        check("rst_byp_rd2B", rd2B, 32'h0);
        check("rst_rd1N", rd1N, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        #1;
        check("x3_after_rst_B", rd1B, 32'h0);
        check("x3_after_rst_N", rd1N, 32'h0);
        check("x7_after_rst", rd2B, 32'h0);

        // Random traffic against the array model
        for (int c = 0; c < 10000; c++) begin
            logic [4:0] rd;
            rst = ($urandom_range(63) == 0);
            rd  = 5'($urandom);
            drive(1'($urandom), rd, $urandom,
                  5'($urandom), 5'($urandom));
            if ($urandom_range(3) == 0) rs1D = rd;
            if ($urandom_range(3) == 0) rs2D = rs1D;
            #1;
            check("rnd_rd1B", rd1B, expRead(rs1D, 1'b1));
            check("rnd_rd2B", rd2B, expRead(rs2D, 1'b1));
            check("rnd_rd1N", rd1N, expRead(rs1D, 1'b0));
            check("rnd_rd2N", rd2N, expRead(rs2D, 1'b0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
